// File: rtl/hello_scroller_pkg.sv
// -----------------------------------------------------------------------------
// hello_scroller_pkg
// Shared definitions for the HELLO message scroller and its consumers (the
// per-digit character decoders and the testbench).
//   - char_t        : 3-bit character code type
//   - CH_*          : character code constants (H, E, L, O, blank)
//   - MSG_LEN/POS_W : message length and scroll-position width
//   - msg_char(idx) : message ROM, "HELLO" followed by three blanks
// -----------------------------------------------------------------------------
package hello_scroller_pkg;

    typedef logic [2:0] char_t;

    localparam char_t CH_H     = 3'b000;
    localparam char_t CH_E     = 3'b001;
    localparam char_t CH_L     = 3'b010;
    localparam char_t CH_O     = 3'b011;
    localparam char_t CH_BLANK = 3'b100;

    localparam int MSG_LEN = 8;
    localparam int POS_W   = $clog2(MSG_LEN);

    // Message ROM. Codes 101..111 are never produced; out-of-range slots
    // cannot occur because the index is exactly POS_W bits wide.
    function automatic char_t msg_char(input logic [POS_W-1:0] idx);
        char_t c;
        case (idx)
            3'd0:    c = CH_H;
            3'd1:    c = CH_E;
            3'd2:    c = CH_L;
            3'd3:    c = CH_L;
            3'd4:    c = CH_O;
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

endpackage : hello_scroller_pkg

// File: rtl/rate_tick.sv
// -----------------------------------------------------------------------------
// rate_tick
// Divides the clock down to a one-cycle Tick every TICK_DIV cycles while
// Enable is high. The counter is held at zero while Enable is low, so the
// first Tick after Enable rises lands on the TICK_DIV-th edge with Enable
// sampled high.
// Ports:
//   Clock  : system clock, rising edge
//   Reset  : asynchronous, active-high reset (counter to 0)
//   Enable : 1 = count, 0 = clear counter every clock
//   Tick   : combinational, high during the cycle whose rising edge is the
//            terminal count edge (cnt == TICK_DIV-1 with Enable high)
// -----------------------------------------------------------------------------
module rate_tick #(
    parameter int TICK_DIV = 25000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    output logic Tick
);

    // TICK_DIV == 1 would give a zero-width counter; keep at least one bit.
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = '0;
        Tick  = 1'b0;
        if (Enable) begin
            if (cnt_q == LAST) begin
                Tick = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : rate_tick

// File: rtl/hello_scroller.sv
// -----------------------------------------------------------------------------
// hello_scroller
// Scrolls "HELLO" plus three blanks across NUM_DIGITS HEX displays, producing
// the 3-bit character codes for the per-digit 7-segment decoders. Advances
// come from the divided-clock tick (Enable=1) or from single Step pulses
// (Enable=0); Dir selects left (pos+1) or right (pos-1).
// Ports:
//   Clock  : system clock, rising edge
//   Reset  : asynchronous, active-high reset
//   Enable : 1 = automatic scrolling every TICK_DIV clocks; 0 = manual
//   Dir    : 0 = scroll left (pos+1), 1 = scroll right (pos-1)
//   Step   : one-cycle pulse, advances one position while Enable=0
//   Codes  : Codes[3*i+:3] drives display i; display NUM_DIGITS-1 is leftmost
//   Wrap   : one-cycle pulse after an advance that lands on position 0
// -----------------------------------------------------------------------------
module hello_scroller
    import hello_scroller_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    Dir,
    input  logic                    Step,
    output logic [3*NUM_DIGITS-1:0] Codes,
    output logic                    Wrap
);

    localparam int CODES_W = 3 * NUM_DIGITS;

    // Display image for a scroll position: the leftmost display shows
    // msg[pos], each display to its right shows the next slot, modulo 8
    // (the POS_W-bit sum wraps naturally).
    function automatic logic [CODES_W-1:0] image_of(input logic [POS_W-1:0] p);
        logic [CODES_W-1:0] img;
        img = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            img[3*(NUM_DIGITS-1-k) +: 3] = msg_char(p + POS_W'(k));
        end
        return img;
    endfunction

    logic               tick;
    logic               advance;
    logic [POS_W-1:0]   pos_q,   pos_d;
    logic [CODES_W-1:0] codes_q, codes_d;
    logic               wrap_q,  wrap_d;

    rate_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_rate_tick (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (Enable),
        .Tick   (tick)
    );

    // Step is ignored in auto mode; the tick is inactive in manual mode
    // because rate_tick holds its counter cleared.
    always_comb begin
        advance = Enable ? tick : Step;
        pos_d   = pos_q;
        if (advance) begin
            pos_d = Dir ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
        end
        // Outputs are built from next-pos so they change on the advance edge.
        wrap_d  = advance && (pos_d == '0);
        codes_d = image_of(pos_d);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            codes_q <= image_of('0);
        end else begin
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            codes_q <= codes_d;
        end
    end

    assign Codes = codes_q;
    assign Wrap  = wrap_q;

endmodule : hello_scroller

// File: tb/tb_hello_scroller.sv
// -----------------------------------------------------------------------------
// tb_hello_scroller
// Directed testbench for hello_scroller with NUM_DIGITS=8, TICK_DIV=4.
// Inputs are driven just after the falling edge; outputs are sampled on the
// falling edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_hello_scroller;
    import hello_scroller_pkg::*;

    localparam int NUM_DIGITS = 8;
    localparam int TICK_DIV   = 4;

    logic                    clk;
    logic                    rst;
    logic                    en;
    logic                    dir;
    logic                    step;
    logic [3*NUM_DIGITS-1:0] codes;
    logic                    wrap;

    int total = 0;
    int bad   = 0;

    // Hand-derived display images for positions 0..7.
    logic [23:0] img [8];

    hello_scroller #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV)
    ) dut (
        .Clock  (clk),
        .Reset  (rst),
        .Enable (en),
        .Dir    (dir),
        .Step   (step),
        .Codes  (codes),
        .Wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and compare both outputs against the expected position.
    task automatic edge_check(input string tag, input int exp_pos, input logic exp_wrap);
        @(negedge clk);
        check({tag, " codes"}, 32'(codes), 32'(img[exp_pos]));
        check({tag, " wrap"},  32'(wrap),  32'(exp_wrap));
    endtask

    initial begin
        img[0] = 24'h052724;  // H E L L O _ _ _
        img[1] = 24'h293920;  // E L L O _ _ _ H
        img[2] = 24'h49C901;  // L L O _ _ _ H E
        img[3] = 24'h4E480A;  // L O _ _ _ H E L
        img[4] = 24'h724052;  // O _ _ _ H E L L
        img[5] = 24'h920293;  // _ _ _ H E L L O
        img[6] = 24'h90149C;  // _ _ H E L L O _
        img[7] = 24'h80A4E4;  // _ H E L L O _ _

        rst = 1'b1; en = 1'b0; dir = 1'b0; step = 1'b0;
        #1;
        check("reset codes", 32'(codes), 32'(img[0]));
        check("reset wrap",  32'(wrap),  32'd0);
        @(negedge clk);
        @(negedge clk);

        // Auto scroll left: advance every 4th edge, full revolution in 32.
        rst = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            edge_check($sformatf("left e%0d", i), (i / 4) % 8, (i == 32));
        end
        en = 1'b0;
        edge_check("left after wrap", 0, 1'b0);

        // Asynchronous reset mid-scroll with Enable held high.
        en = 1'b1;
        repeat (5) @(negedge clk);
        check("pre-reset codes", 32'(codes), 32'(img[1]));
        #2 rst = 1'b1;
        #1;
        check("async reset codes", 32'(codes), 32'(img[0]));
        check("async reset wrap",  32'(wrap),  32'd0);
        @(negedge clk);

        // Auto scroll right: 0 -> 7 on the 4th edge, then 7 more steps to 0.
        dir = 1'b1;
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            edge_check($sformatf("right e%0d", i), (8 - i / 4) % 8, (i == 32));
        end
        // Wrap is high right now; reset mid-cycle must clear it at once.
        #2 rst = 1'b1;
        #1;
        check("async reset clears wrap", 32'(wrap),  32'd0);
        check("async reset right codes", 32'(codes), 32'(img[0]));
        @(negedge clk);

        // Manual stepping, left.
        rst = 1'b0; en = 1'b0; dir = 1'b0;
        edge_check("manual idle", 0, 1'b0);
        for (int s = 1; s <= 3; s++) begin
            step = 1'b1;
            edge_check($sformatf("manual step%0d", s), s, 1'b0);
            step = 1'b0;
            edge_check($sformatf("manual hold%0d", s), s, 1'b0);
        end

        // Step ignored while Enable=1; only the normal 4th-edge tick advances.
        en = 1'b1; step = 1'b1;
        edge_check("step ignored e1", 3, 1'b0);
        step = 1'b0;
        edge_check("step ignored e2", 3, 1'b0);
        edge_check("step ignored e3", 3, 1'b0);
        edge_check("step ignored e4", 4, 1'b0);

        // Enable for 3 edges, drop for 1 (counter clears), re-enable.
        for (int i = 1; i <= 3; i++) edge_check($sformatf("pre-drop e%0d", i), 4, 1'b0);
        en = 1'b0;
        edge_check("dropped", 4, 1'b0);
        en = 1'b1;
        for (int i = 1; i <= 3; i++) edge_check($sformatf("re-en e%0d", i), 4, 1'b0);
        edge_check("re-en e4", 5, 1'b0);

        // Dir change mid-count: only the next advance uses it, no extra step.
        edge_check("dir e1", 5, 1'b0);
        edge_check("dir e2", 5, 1'b0);
        dir = 1'b1;
        edge_check("dir e3", 5, 1'b0);
        edge_check("dir e4", 4, 1'b0);
        edge_check("dir e5", 4, 1'b0);
        edge_check("dir e6", 4, 1'b0);
        edge_check("dir e7", 4, 1'b0);
        edge_check("dir e8", 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hello_scroller
